dmem_responder: RTL and testbench

- Data-memory responder at the far end of the core's load/store request/response interface.
- Accepts one word-aligned read or write at a time and inserts a configurable number of wait states.
- Returns read data or a write acknowledgement, with an error flag for bad addresses.
- Sits beside the risc core in the top level; it is the memory the core's LSU talks to.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory responder with wait states (optional DMEM_STATS_EN access counters)
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_next;
    logic              accept;
    logic              commit;
    logic              resp_done;

    logic [32:0]       offset;
    logic              addr_err;

    logic              cap_we;
    logic              cap_err;
    logic [IDX_W-1:0]  cap_idx;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_be;

    logic [31:0]       mem [DEPTH_WORDS];

    // Decode the incoming address; a borrow in offset means the address is below the window
    always_comb begin
        offset   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        addr_err = (req_addr[1:0] != 2'b00) || offset[32] || (offset >= SPAN);
    end

    // Next-state logic; the counter holds the number of wait states still to run before commit
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        commit        = 1'b0;
        resp_done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept        = 1'b1;
                    state_next    = S_WAIT;
                    wait_cnt_next = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    commit     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    // State register and response outputs; the response is formed on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (commit) begin
                resp_err   <= cap_err;
                resp_rdata <= (cap_err || cap_we) ? 32'd0 : mem[cap_idx];
            end else if (resp_done) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Request capture; only this copy is used after accept, so later input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_err   <= addr_err;
            cap_idx   <= offset[IDX_W+1:2];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // Byte-lane write on the commit edge; a reset in the same cycle cancels the write
    always_ff @(posedge clk) begin
        if (!reset && commit && cap_we && !cap_err) begin
            for (int b = 0; b < 4; b++) begin
                if (cap_be[b]) begin
                    mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating access counters, advanced on the response handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count  <= 16'd0;
            wr_count  <= 16'd0;
            err_count <= 16'd0;
        end else if (resp_done) begin
            if (resp_err) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else if (cap_we) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at WAIT_CYCLES 1, 3 and 0
module tb_dmem_responder;

    localparam int NI = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset      [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_be     [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];
`ifdef DMEM_STATS_EN
    logic [15:0] rd_count   [NI];
    logic [15:0] wr_count   [NI];
    logic [15:0] err_count  [NI];
`endif

    exp_t sbq [NI][$];
    int   acc_cycle [NI];
    logic prev_v [NI];
    int   cycle   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (256),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
            .BASE_ADDR   (32'h0000_1000)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
`ifdef DMEM_STATS_EN
            ,
            .rd_count   (rd_count[g]),
            .wr_count   (wr_count[g]),
            .err_count  (err_count[g])
`endif
        );
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rd, input logic exp_err, input bit track);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_be[i]    = be;
        req_valid[i] = 1'b1;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout inst %0d addr %h: req_ready stayed %b, required 1", i, addr, req_ready[i]);
            req_valid[i] = 1'b0;
            return;
        end
        if (track) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            sbq[i].push_back(e);
        end
        acc_cycle[i] = cycle + 1;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (sbq[i].size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout inst %0d: %0d responses outstanding, required 0", i, sbq[i].size());
            sbq[i].delete();
        end
    endtask

    task automatic chk_reset_vals(input int i, input string tag);
        chk({tag, "_req_ready"},  32'(req_ready[i]),  32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid[i]), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata[i],      32'd0);
        chk({tag, "_resp_err"},   32'(resp_err[i]),   32'd0);
    endtask

    // Monitor: latency on each new response, then scoreboard compare on the handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (reset[i]) begin
                    prev_v[i] = 1'b0;
                end else begin
                    if (resp_valid[i] && !prev_v[i]) begin
                        n_checks++;
                        if (cycle - acc_cycle[i] != 1 + wait_of(i)) begin
                            n_fail++;
                            $display("FAIL latency inst %0d: got %0d cycles, required %0d",
                                     i, cycle - acc_cycle[i], 1 + wait_of(i));
                        end
                    end
                    if (resp_valid[i] && resp_ready[i]) begin
                        n_checks++;
                        if (sbq[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_resp inst %0d: rdata %h err %b with none outstanding",
                                     i, resp_rdata[i], resp_err[i]);
                        end else begin
                            e = sbq[i].pop_front();
                            if (resp_rdata[i] !== e.rdata || resp_err[i] !== e.err) begin
                                n_fail++;
                                $display("FAIL resp inst %0d: got rdata %h err %b, required rdata %h err %b",
                                         i, resp_rdata[i], resp_err[i], e.rdata, e.err);
                            end
                        end
                    end
                    prev_v[i] = resp_valid[i];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            reset[i]      = 1'b1;
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            req_be[i]     = 4'h0;
            resp_ready[i] = 1'b1;
            acc_cycle[i]  = 0;
            prev_v[i]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk_reset_vals(i, "por");
`ifdef DMEM_STATS_EN
            chk("por_rd_count",  32'(rd_count[i]),  32'd0);
            chk("por_wr_count",  32'(wr_count[i]),  32'd0);
            chk("por_err_count", 32'(err_count[i]), 32'd0);
`endif
            reset[i] = 1'b0;
        end

        // WAIT_CYCLES = 1: basic, byte enables, errors
        issue(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1); wait_done(0);
        issue(0, 1'b0, 32'h0000_1000, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1); wait_done(0);
        issue(0, 1'b1, 32'h0000_1004, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1); wait_done(0);
        issue(0, 1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1'b1); wait_done(0);
        issue(0, 1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 1'b1); wait_done(0);
        issue(0, 1'b0, 32'h0000_1002, 32'h0,         4'hF, 32'h0, 1'b1, 1'b1); wait_done(0);
        issue(0, 1'b1, 32'h0000_0FFC, 32'h0000_0005, 4'hF, 32'h0, 1'b1, 1'b1); wait_done(0);
        issue(0, 1'b0, 32'h0000_1400, 32'h0,         4'hF, 32'h0, 1'b1, 1'b1); wait_done(0);
        issue(0, 1'b1, 32'h0000_1000, 32'h0BAD_0BAD, 4'h0, 32'h0, 1'b0, 1'b1); wait_done(0);
        issue(0, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1); wait_done(0);

        // Response backpressure with a second request held pending
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h0000_1004;
        req_be[0]    = 4'hF;
        req_valid[0] = 1'b1;
        begin
            exp_t e2;
            e2.rdata = 32'h11BB_33DD;
            e2.err   = 1'b0;
            sbq[0].push_back(e2);
        end
        n = 0;
        while (!resp_valid[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_resp_seen", 32'(resp_valid[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
            chk("bp_resp_rdata", resp_rdata[0],      32'hDEAD_BEEF);
            chk("bp_req_ready",  32'(req_ready[0]),  32'd0);
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b1;
        acc_cycle[0]  = cycle + 2;
        @(posedge clk); #1;
        chk("bp_after_hs_valid", 32'(resp_valid[0]), 32'd0);
        chk("bp_after_hs_ready", 32'(req_ready[0]),  32'd1);
        @(posedge clk); #1;
        chk("bp_second_accepted", 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        wait_done(0);

        // WAIT_CYCLES = 3: reset during WAIT discards the write
        issue(1, 1'b1, 32'h0000_1008, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1); wait_done(1);
        issue(1, 1'b1, 32'h0000_1008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0);
        chk("midwr_in_wait_ready", 32'(req_ready[1]), 32'd0);
        reset[1] = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals(1, "midwr");
        reset[1] = 1'b0;
        issue(1, 1'b0, 32'h0000_1008, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1); wait_done(1);

        // WAIT_CYCLES = 0: 3 reads, 2 writes, 1 error
        issue(2, 1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF, 32'h0, 1'b0, 1'b1); wait_done(2);
        issue(2, 1'b1, 32'h0000_1004, 32'h0000_0002, 4'hF, 32'h0, 1'b0, 1'b1); wait_done(2);
        issue(2, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h0000_0001, 1'b0, 1'b1); wait_done(2);
        issue(2, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 32'h0000_0002, 1'b0, 1'b1); wait_done(2);
        issue(2, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h0000_0001, 1'b0, 1'b1); wait_done(2);
        issue(2, 1'b0, 32'h0000_1001, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1); wait_done(2);
`ifdef DMEM_STATS_EN
        chk("stats_rd_count",  32'(rd_count[2]),  32'd3);
        chk("stats_wr_count",  32'(wr_count[2]),  32'd2);
        chk("stats_err_count", 32'(err_count[2]), 32'd1);
`endif
        reset[2] = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals(2, "w0_reset");
`ifdef DMEM_STATS_EN
        chk("stats_rd_clear",  32'(rd_count[2]),  32'd0);
        chk("stats_wr_clear",  32'(wr_count[2]),  32'd0);
        chk("stats_err_clear", 32'(err_count[2]), 32'd0);
`endif
        reset[2] = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
